// File: rtl/rf_dump_reader_if.sv
// Register-file read port plus the valid/ready dump stream, grouped for rf_dump_reader.
// master = the reader, slave = register file / consumer side.
interface rf_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_idx;
  logic [DATA_W-1:0] out_data;

  modport master (
    output rf_addr, input rf_data,
    output out_valid, input out_ready, output out_idx, output out_data
  );
  modport slave (
    input rf_addr, output rf_data,
    input out_valid, output out_ready, input out_idx, input out_data
  );
endinterface

// File: rtl/rf_dump_reader.sv
// Walks register indices 0..NUM_REGS-1 on a start pulse and streams {idx, data} over valid/ready.
// Optional RF_DUMP_CHECKSUM_EN adds checksum_o, the XOR of every entry accepted in the current dump.
module rf_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  rf_dump_reader_if.master bus,
  output logic busy_o,
  output logic done_o
`ifdef RF_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum_o
`endif
);

  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q,   cnt_d;
  logic              vld_q,   vld_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              hs;
  logic              last;

  assign hs   = (state_q == SEND) && vld_q && bus.out_ready;
  assign last = (cnt_q == ADDR_W'(NUM_REGS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = READ;
        cnt_d   = '0;
      end
      // Register-file read is combinational, so the entry is captured one cycle after rf_addr moves.
      READ: begin
        data_d  = bus.rf_data;
        idx_d   = cnt_q;
        vld_d   = 1'b1;
        state_d = SEND;
      end
      SEND: if (hs) begin
        vld_d = 1'b0;
        if (last) state_d = FIN;
        else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = READ;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign bus.rf_addr   = cnt_q;
  assign bus.out_valid = vld_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_data  = data_q;
  assign busy_o        = (state_q == READ) || (state_q == SEND);
  assign done_o        = (state_q == FIN);

`ifdef RF_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] cs_q, cs_d;

  // Holds its final value from FIN until the next accepted start clears it.
  always_comb begin
    cs_d = cs_q;
    if (state_q == IDLE && start_i) cs_d = '0;
    else if (hs)                    cs_d = cs_q ^ data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cs_q <= '0;
    else       cs_q <= cs_d;
  end

  assign checksum_o = cs_q;
`endif

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: per-cycle compare against a phase/queue model plus literal checks.
module tb_rf_dump_reader;
  localparam int N = 32;

  logic clk, rst, start, ready, busy, done;
  logic [31:0] rf_mem [N];
  logic [31:0] snap   [N];
`ifdef RF_DUMP_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  rf_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  assign bus.rf_data   = rf_mem[bus.rf_addr];
  assign bus.out_ready = ready;

  rf_dump_reader #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus),
    .busy_o(busy), .done_o(done)
`ifdef RF_DUMP_CHECKSUM_EN
    , .checksum_o(checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: dump phase + expected entry sequence ----------------
  typedef enum {P_IDLE, P_ACT, P_FIN} ph_t;
  ph_t         ph;
  int          m_idx;
  logic        first, prev_vld, prev_hs, hs, exp_vld;
  logic [31:0] m_cs;
  int          n_hs = 0, n_busy = 0, n_done = 0;
  logic [31:0] log_idx [1024];
  logic [31:0] log_dat [1024];

  always @(negedge clk) begin
    if (rst) begin
      ph = P_IDLE; m_idx = 0; first = 1'b0; prev_vld = 1'b0; prev_hs = 1'b0; m_cs = '0;
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, ph == P_ACT});
      chk("done", {31'd0, done}, {31'd0, ph == P_FIN});
      if (ph != P_ACT)  exp_vld = 1'b0;
      else if (first)   exp_vld = 1'b0;
      else if (prev_vld) exp_vld = !prev_hs;
      else              exp_vld = 1'b1;
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_vld});
      if (bus.out_valid && ph == P_ACT) begin
        chk("out_idx",  32'(bus.out_idx), 32'(m_idx));
        chk("out_data", bus.out_data, snap[m_idx]);
      end
`ifdef RF_DUMP_CHECKSUM_EN
      chk("checksum", checksum, m_cs);
`endif
      hs = bus.out_valid && ready;
      if (hs && n_hs < 1024) begin
        log_idx[n_hs] = 32'(bus.out_idx);
        log_dat[n_hs] = bus.out_data;
      end
      if (hs)   n_hs++;
      if (done) n_done++;
      if (busy) n_busy++;
      first = 1'b0;
      case (ph)
        P_IDLE: if (start) begin
          ph = P_ACT; m_idx = 0; first = 1'b1; m_cs = '0; snap = rf_mem;
        end
        P_ACT: if (hs) begin
          m_cs = m_cs ^ bus.out_data;
          if (m_idx == N - 1) ph = P_FIN;
          else m_idx++;
        end
        default: ph = P_IDLE;
      endcase
      prev_vld = bus.out_valid;
      prev_hs  = hs;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // idx < 0 means any valid entry
  task automatic wait_entry(input int idx, input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      if (bus.out_valid && (idx < 0 || 32'(bus.out_idx) == 32'(idx))) break;
      tick();
    end
    if (k == limit) chk("wait_entry_timeout", 32'(idx), 32'hFFFF_FFFF);
  endtask

  task automatic wait_done(input int limit);
    int base, k;
    base = n_done;
    for (k = 0; k < limit && n_done == base; k++) tick();
    if (n_done == base) chk("wait_done_timeout", 32'(n_done), 32'(base + 1));
  endtask

  int b_hs, b_busy, b_done;

  initial begin
    rst = 1'b0; start = 1'b0; ready = 1'b1;
    for (int i = 0; i < N; i++) rf_mem[i] = 32'(i * 4 + 1);
    rf_mem[0] = 32'd0;
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_addr",  32'(bus.rf_addr), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // full dump, ready held high
    b_hs = n_hs; b_busy = n_busy; b_done = n_done;
    pulse_start();
    wait_done(200);
    tick();
    chk("full_entries", 32'(n_hs - b_hs), 32'd32);
    chk("full_busy_cycles", 32'(n_busy - b_busy), 32'd64);
    chk("full_done_pulses", 32'(n_done - b_done), 32'd1);
    chk("full_idx0_data", log_dat[b_hs], 32'd0);
    chk("full_idx1_data", log_dat[b_hs + 1], 32'd5);
    chk("full_idx31_idx", log_idx[b_hs + 31], 32'd31);
    chk("full_idx31_data", log_dat[b_hs + 31], 32'd125);

    // backpressure on idx 3, then a start while busy at idx 10
    b_hs = n_hs; b_done = n_done;
    pulse_start();
    wait_entry(3, 50);
    ready = 1'b0;
    rf_mem[3] = 32'hDEAD_BEEF;
    repeat (5) begin
      tick();
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_idx",   32'(bus.out_idx), 32'd3);
      chk("stall_data",  bus.out_data, 32'd13);
    end
    ready = 1'b1;
    tick();
    chk("after_hs_valid", {31'd0, bus.out_valid}, 32'd0);
    rf_mem[3] = 32'd13;
    wait_entry(-1, 10);
    chk("next_idx",  32'(bus.out_idx), 32'd4);
    chk("next_data", bus.out_data, 32'd17);
    wait_entry(10, 50);
    pulse_start();
    wait_done(200);
    repeat (3) tick();
    chk("ign_entries", 32'(n_hs - b_hs), 32'd32);
    chk("ign_done_pulses", 32'(n_done - b_done), 32'd1);
    chk("ign_idle_busy", {31'd0, busy}, 32'd0);

    // reset mid-dump
    pulse_start();
    wait_entry(7, 50);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    chk("mid_rst_done",  {31'd0, done}, 32'd0);
    chk("mid_rst_addr",  32'(bus.rf_addr), 32'd0);
    chk("mid_rst_idx",   32'(bus.out_idx), 32'd0);
    chk("mid_rst_data",  bus.out_data, 32'd0);
    b_done = n_done;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("mid_rst_no_done", 32'(n_done), 32'(b_done));
    pulse_start();
    wait_entry(-1, 10);
    chk("restart_idx",  32'(bus.out_idx), 32'd0);
    chk("restart_data", bus.out_data, 32'd0);
    wait_done(200);
    tick();

`ifdef RF_DUMP_CHECKSUM_EN
    for (int i = 0; i < N; i++) rf_mem[i] = 32'(i);
    pulse_start();
    wait_done(200);
    tick();
    chk("cs_ramp", checksum, 32'd0);
    rf_mem[5] = 32'hFFFF_0005;
    pulse_start();
    wait_done(200);
    repeat (2) tick();
    chk("cs_ramp_r5", checksum, 32'hFFFF_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rf_dump_reader.md
Name: rf_dump_reader

Overview:
- Sequential reader for the CPU register file.
- On a start pulse, typically the rising edge of the core's halt indication, it walks register indices 0..NUM_REGS-1 through one register-file read port.
- Each value is emitted with its index on a valid/ready stream toward the testbench or debug logger.
- Gives the register-file contents a handshaked, backpressure-tolerant read-out path instead of a flat array port.

Parameters:
NUM_REGS, 32, number of registers walked (indices 0..NUM_REGS-1)
ADDR_W, 5, register index width; must satisfy 2^ADDR_W >= NUM_REGS
DATA_W, 32, register data width

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a dump; sampled on rising clk
rf_addr  output  ADDR_W  register index driven to the register-file read port (rs1 side)
rf_data  input  DATA_W  asynchronous read data returned for rf_addr in the same cycle
out_valid  output  1  out_idx/out_data hold a valid entry
out_ready  input  1  consumer accepts the entry when high with out_valid
out_idx  output  ADDR_W  index of the emitted register
out_data  output  DATA_W  value of the emitted register
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last entry is accepted

Behaviour:
- Reset is asynchronous and active-high. On assertion, all state and outputs clear immediately: state=IDLE, counter=0, rf_addr=0, out_valid=0, out_idx=0, out_data=0, busy=0, done=0.
- rf_addr is a registered counter output, never combinational from start.
- FSM states IDLE, READ, SEND, FIN:
  - IDLE: when start=1 at an edge, go to READ with counter=0; busy=1 from the next cycle.
  - READ: rf_addr=counter; at the edge, capture out_data<=rf_data and out_idx<=counter, set out_valid=1, go to SEND. One-cycle read latency, because the register-file read is combinational.
  - SEND: hold out_valid, out_idx, and out_data stable until out_valid&&out_ready at an edge. On handshake, out_valid=0.
    - If counter==NUM_REGS-1, go to FIN.
    - Otherwise counter+1 and go to READ.
  - FIN: done=1 for exactly this one cycle, busy=0 in this cycle; go to IDLE.
- Throughput with out_ready held high: 2 cycles per register. A full dump takes 2*NUM_REGS cycles from the first READ to the last handshake, then 1 FIN cycle.
- start while busy (READ/SEND/FIN) is ignored; no restart or queueing.
- start in the same cycle as a pending handshake has no effect.
- out_ready without out_valid has no effect.
- out_ready held low stalls indefinitely in SEND with all outputs stable. Register-file writes during a stall are not reflected in the already-captured entry.
- Index 0 is emitted like any other register; the register file returns 0 for it.
- The counter never wraps past NUM_REGS-1.
- Reset mid-dump aborts immediately: no done pulse, and the next start restarts at index 0.

Optional Feature:
- RF_DUMP_CHECKSUM_EN defined:
  - Adds output port checksum (DATA_W): running XOR of every out_data accepted by a handshake in the current dump.
  - Cleared to 0 when start is accepted and on reset.
  - Final value is valid and stable from the FIN cycle until the next accepted start.
- Not defined: the checksum port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset state: assert reset mid-cycle with clk idle -> out_valid=0, busy=0, done=0, rf_addr=0 without any clock edge.
- Full dump, out_ready=1: model rf[i]=i*4+1 and rf[0]=0, pulse start -> 32 entries (idx 0..31, data 0,5,9,...,125) one every 2 cycles; done pulses 1 cycle after idx 31 is accepted; busy high for 64 cycles.
- Backpressure: drop out_ready for 5 cycles while idx 3 (data 13) is presented -> out_valid, out_idx=3, out_data=13 stable throughout; idx 4 appears only after the handshake.
- Ignored start: pulse start again while at idx 10 -> dump continues to idx 31 with one done pulse, then IDLE.
- Reset mid-dump: assert reset at idx 7 -> outputs clear and no done pulse; the next start emits idx 0 first.
- RF_DUMP_CHECKSUM_EN: rf[i]=i for all i, full dump -> checksum=0 (XOR of 0..31); repeat with rf[5]=0xFFFF_0005 -> checksum=0xFFFF_0000.
